// File: rtl/gyro_mod_demod_if.sv
// Bus bundle for the gyro modulation/demodulation stage: run control,
// half-period configuration, ADC samples in, phase/error/strobe out.
interface gyro_mod_demod_if #(
    parameter int unsigned ADC_W = 14,
    parameter int unsigned ACC_W = 32
);
    logic                    i_en;
    logic [15:0]             i_freq_cnt;
    logic [15:0]             i_wait_cnt;
    logic                    i_polarity;
    logic signed [ADC_W-1:0] i_adc;
    logic                    o_mod_out;
    logic signed [ACC_W-1:0] o_err;
    logic                    o_trig;
    logic [1:0]              o_cstate;

    // Controller/ADC side drives the inputs and observes the results.
    modport master (
        output i_en, i_freq_cnt, i_wait_cnt, i_polarity, i_adc,
        input  o_mod_out, o_err, o_trig, o_cstate
    );

    // Demodulator side.
    modport slave (
        input  i_en, i_freq_cnt, i_wait_cnt, i_polarity, i_adc,
        output o_mod_out, o_err, o_trig, o_cstate
    );
endinterface

// File: rtl/gyro_mod_demod.sv
// Square-wave phase modulator and synchronous demodulator. Accumulates the
// settled ADC samples of each half-period and, once per full period, emits
// the saturated high-minus-low difference with a one-cycle strobe.
module gyro_mod_demod #(
    parameter int unsigned ADC_W = 14,
    parameter int unsigned ACC_W = 32
) (
    input logic             i_clk,
    input logic             i_rst,
    gyro_mod_demod_if.slave bus
);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned EXT_W = ACC_W - ADC_W;

    localparam logic [ACC_W-1:0] ERR_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ERR_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HALF_H = 2'd1,
        HALF_L = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        freq_q;
    logic [CNT_W-1:0]        wait_q;
    logic                    pol_q;
    logic signed [ACC_W-1:0] sum_h;
    logic signed [ACC_W-1:0] sum_l;
    logic signed [ACC_W-1:0] err_q;
    logic                    mod_q;
    logic                    trig_q;

    logic signed [ACC_W-1:0] sample_c;
    logic                    take_c;
    logic                    last_c;
    logic [CNT_W-1:0]        freq_eff_c;
    logic signed [ACC_W-1:0] sum_l_fin_c;
    logic signed [ACC_W:0]   diff_c;
    logic signed [ACC_W-1:0] sat_c;

    // Sample qualification and end-of-half detection.
    assign sample_c   = {{EXT_W{bus.i_adc[ADC_W-1]}}, bus.i_adc};
    assign take_c     = (cnt >= wait_q);
    assign last_c     = (cnt == (freq_q - CNT_W'(1)));
    assign freq_eff_c = (bus.i_freq_cnt < CNT_W'(2)) ? CNT_W'(2) : bus.i_freq_cnt;

    // Low-half sum including the final sample taken on the wrap edge.
    assign sum_l_fin_c = take_c ? (sum_l + sample_c) : sum_l;

    // One extra bit so the difference itself never overflows before saturation.
    assign diff_c = pol_q
        ? ($signed({sum_l_fin_c[ACC_W-1], sum_l_fin_c}) - $signed({sum_h[ACC_W-1], sum_h}))
        : ($signed({sum_h[ACC_W-1], sum_h}) - $signed({sum_l_fin_c[ACC_W-1], sum_l_fin_c}));

    // Clamp when the top two bits disagree.
    assign sat_c = (diff_c[ACC_W] != diff_c[ACC_W-1])
        ? (diff_c[ACC_W] ? $signed(ERR_MIN) : $signed(ERR_MAX))
        : diff_c[ACC_W-1:0];

    // Modulation FSM, half-period counting, accumulation and result strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            freq_q <= '0;
            wait_q <= '0;
            pol_q  <= 1'b0;
            sum_h  <= '0;
            sum_l  <= '0;
            err_q  <= '0;
            mod_q  <= 1'b0;
            trig_q <= 1'b0;
        end else begin
            trig_q <= 1'b0;
            if (!bus.i_en) begin
                // Disable aborts the period; the last error is kept.
                state <= IDLE;
                mod_q <= 1'b0;
                cnt   <= '0;
                sum_h <= '0;
                sum_l <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state  <= HALF_H;
                        mod_q  <= 1'b1;
                        cnt    <= '0;
                        freq_q <= freq_eff_c;
                        wait_q <= bus.i_wait_cnt;
                        pol_q  <= bus.i_polarity;
                        sum_h  <= '0;
                        sum_l  <= '0;
                    end
                    HALF_H: begin
                        if (take_c) begin
                            sum_h <= sum_h + sample_c;
                        end
                        if (last_c) begin
                            // Low sum starts empty; its first sample arrives next edge.
                            state <= HALF_L;
                            mod_q <= 1'b0;
                            cnt   <= '0;
                            sum_l <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    HALF_L: begin
                        if (last_c) begin
                            err_q  <= sat_c;
                            trig_q <= 1'b1;
                            state  <= HALF_H;
                            mod_q  <= 1'b1;
                            cnt    <= '0;
                            sum_h  <= '0;
                            sum_l  <= sum_l_fin_c;
                            freq_q <= freq_eff_c;
                            wait_q <= bus.i_wait_cnt;
                            pol_q  <= bus.i_polarity;
                        end else begin
                            if (take_c) begin
                                sum_l <= sum_l + sample_c;
                            end
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        mod_q <= 1'b0;
                        cnt   <= '0;
                        sum_h <= '0;
                        sum_l <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.o_mod_out = mod_q;
    assign bus.o_err     = err_q;
    assign bus.o_trig    = trig_q;
    assign bus.o_cstate  = state;
endmodule

// File: tb/tb_gyro_mod_demod.sv
// Bench for gyro_mod_demod: two instances (32-bit and 16-bit accumulators)
// share one stimulus stream and are compared every cycle against a
// period-position model, plus directed literal expectations.
module tb_gyro_mod_demod;
    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en = 1'b0;
    logic [15:0]         freq = 16'd4;
    logic [15:0]         wt = 16'd0;
    logic                pol = 1'b0;
    logic signed [13:0]  adc = '0;

    int n_cmp = 0;
    int n_bad = 0;

    gyro_mod_demod_if #(.ADC_W(14), .ACC_W(32)) b32 ();
    gyro_mod_demod_if #(.ADC_W(14), .ACC_W(16)) b16 ();

    assign b32.i_en = en;
    assign b32.i_freq_cnt = freq;
    assign b32.i_wait_cnt = wt;
    assign b32.i_polarity = pol;
    assign b32.i_adc = adc;
    assign b16.i_en = en;
    assign b16.i_freq_cnt = freq;
    assign b16.i_wait_cnt = wt;
    assign b16.i_polarity = pol;
    assign b16.i_adc = adc;

    gyro_mod_demod #(.ADC_W(14), .ACC_W(32)) dut32 (.i_clk(clk), .i_rst(rst), .bus(b32));
    gyro_mod_demod #(.ADC_W(14), .ACC_W(16)) dut16 (.i_clk(clk), .i_rst(rst), .bus(b16));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The period is a position 0..2f-1; the first f positions are the high half.
    bit     m_run;
    int     m_pos, m_f, m_w, m_idx;
    bit     m_p;
    longint m_sh, m_sl;
    bit     e_mod, e_trig;
    longint e_err32, e_err16;
    int     e_cs;

    function automatic longint wrapw(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic longint result(input longint sh, input longint sl, input bit p, input int w);
        longint d, mx;
        d = p ? (wrapw(sl, w) - wrapw(sh, w)) : (wrapw(sh, w) - wrapw(sl, w));
        mx = (longint'(1) <<< (w - 1)) - 1;
        if (d > mx) d = mx;
        if (d < -mx - 1) d = -mx - 1;
        return d;
    endfunction

    task automatic model_latch();
        m_f = (freq < 16'd2) ? 2 : int'(freq);
        m_w = int'(wt);
        m_p = pol;
        m_pos = 0;
        m_sh = 0;
        m_sl = 0;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_run = 0; m_pos = 0; m_sh = 0; m_sl = 0;
            e_trig = 0; e_err32 = 0; e_err16 = 0;
        end else begin
            e_trig = 0;
            if (!en) begin
                m_run = 0;
            end else if (!m_run) begin
                m_run = 1;
                model_latch();
            end else begin
                m_idx = (m_pos < m_f) ? m_pos : m_pos - m_f;
                if (m_idx >= m_w) begin
                    if (m_pos < m_f) m_sh += longint'(adc);
                    else             m_sl += longint'(adc);
                end
                if (m_pos == 2 * m_f - 1) begin
                    e_err32 = result(m_sh, m_sl, m_p, 32);
                    e_err16 = result(m_sh, m_sl, m_p, 16);
                    e_trig = 1;
                    model_latch();
                end else begin
                    m_pos++;
                end
            end
        end
        e_mod = m_run && (m_pos < m_f);
        e_cs  = !m_run ? 0 : ((m_pos < m_f) ? 1 : 2);
    end

    // Every-cycle comparison, half a clock after the active edge.
    initial forever begin
        @(negedge clk);
        chk("mod32",  longint'(b32.o_mod_out), longint'(e_mod));
        chk("mod16",  longint'(b16.o_mod_out), longint'(e_mod));
        chk("trig32", longint'(b32.o_trig), longint'(e_trig));
        chk("trig16", longint'(b16.o_trig), longint'(e_trig));
        chk("err32",  longint'(b32.o_err), e_err32);
        chk("err16",  longint'(b16.o_err), e_err16);
        chk("cs32",   longint'(b32.o_cstate), longint'(e_cs));
        chk("cs16",   longint'(b16.o_cstate), longint'(e_cs));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Steps while feeding hi during the high half and lo during the low half.
    task automatic drive_steps(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            step();
            adc = b32.o_mod_out ? 14'(hi) : 14'(lo);
        end
    endtask

    task automatic run_phase(input string nm, input int f, input int w, input bit p,
                             input int hi, input int lo, input int ntrig,
                             input longint x32a, input longint x16a,
                             input longint x32b, input longint x16b,
                             input int chg_step, input int chg_f);
        int fe, fe2, steps, last, seen;
        fe  = (f < 2) ? 2 : f;
        fe2 = (chg_step > 0) ? ((chg_f < 2) ? 2 : chg_f) : fe;
        freq = 16'(f); wt = 16'(w); pol = p;
        adc = 14'(lo);
        en = 1'b1;
        steps = 0; seen = 0; last = 0;
        while (seen < ntrig && steps < 2000) begin
            step();
            steps++;
            if (chg_step == steps) freq = 16'(chg_f);
            if (b32.o_trig) begin
                if (seen == 0) begin
                    chk({nm, "_latency"}, steps, 2 * fe + 1);
                    chk({nm, "_err32_first"}, longint'(b32.o_err), x32a);
                    chk({nm, "_err16_first"}, longint'(b16.o_err), x16a);
                end else begin
                    chk({nm, "_period"}, steps - last, 2 * fe2);
                    chk({nm, "_err32"}, longint'(b32.o_err), x32b);
                    chk({nm, "_err16"}, longint'(b16.o_err), x16b);
                end
                last = steps;
                seen++;
            end
            adc = b32.o_mod_out ? 14'(hi) : 14'(lo);
        end
        if (seen < ntrig) chk({nm, "_trig_timeout"}, seen, ntrig);
        en = 1'b0;
        step();
        step();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        longint held;
        step(); step();
        chk("rst_err", longint'(b32.o_err), 0);
        chk("rst_mod", longint'(b32.o_mod_out), 0);
        chk("rst_cs",  longint'(b32.o_cstate), 0);
        rst = 1'b0;
        step(); step();
        chk("idle_cs", longint'(b32.o_cstate), 0);

        run_phase("basic",   4, 1, 1'b0,  100,  -50, 3,  450,  450,  450,  450, 0, 0);
        run_phase("pol1",    4, 1, 1'b1,  100,  -50, 3, -450, -450, -450, -450, 0, 0);
        run_phase("const",   4, 1, 1'b0,   77,   77, 3,    0,    0,    0,    0, 0, 0);
        run_phase("wait4",   4, 4, 1'b0,  100,  -50, 3,    0,    0,    0,    0, 0, 0);
        run_phase("wait9",   4, 9, 1'b0,  100,  -50, 3,    0,    0,    0,    0, 0, 0);
        run_phase("freq0",   0, 0, 1'b0,  100,  -50, 3,  300,  300,  300,  300, 0, 0);
        run_phase("freq1",   1, 0, 1'b0,  100,  -50, 3,  300,  300,  300,  300, 0, 0);
        run_phase("fchg",    4, 0, 1'b0,  100,  -50, 3,  600,  600,  900,  900, 6, 6);
        run_phase("satpos",  4, 0, 1'b0, 8191, -8192, 2,  65532,  32767,  65532,  32767, 0, 0);
        run_phase("satneg",  4, 0, 1'b0, -8192, 8191, 2, -65532, -32768, -65532, -32768, 0, 0);

        // Disable during the low half: no strobe, error held, idle next edge.
        run_phase("pre_en",  4, 1, 1'b0,  100,  -50, 1,  450,  450,  450,  450, 0, 0);
        freq = 16'd4; wt = 16'd1; pol = 1'b0; en = 1'b1;
        drive_steps(6, 100, 40);
        chk("endrop_inlow", longint'(b32.o_cstate), 2);
        en = 1'b0;
        step();
        chk("endrop_mod",  longint'(b32.o_mod_out), 0);
        chk("endrop_trig", longint'(b32.o_trig), 0);
        chk("endrop_err",  longint'(b32.o_err), 450);
        chk("endrop_cs",   longint'(b32.o_cstate), 0);
        step();
        run_phase("reen",    4, 1, 1'b0,  100,  -50, 2,  450,  450,  450,  450, 0, 0);

        // Disable sampled on the wrap edge wins over the strobe.
        freq = 16'd2; wt = 16'd0; pol = 1'b0; en = 1'b1;
        drive_steps(4, 1000, -1000);
        held = longint'(b32.o_err);
        en = 1'b0;
        step();
        chk("wrapdrop_trig", longint'(b32.o_trig), 0);
        chk("wrapdrop_err",  longint'(b32.o_err), held);
        step();

        // Asynchronous reset in the high half clears outputs immediately.
        freq = 16'd4; wt = 16'd1; en = 1'b1;
        drive_steps(3, 100, -50);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_mod",  longint'(b32.o_mod_out), 0);
        chk("arst_err",  longint'(b32.o_err), 0);
        chk("arst_err16", longint'(b16.o_err), 0);
        chk("arst_cs",   longint'(b32.o_cstate), 0);
        en = 1'b0;
        step();
        rst = 1'b0;
        step();
        run_phase("post_rst", 4, 1, 1'b0, 100, -50, 2, 450, 450, 450, 450, 0, 0);

        // Randomised run: checked every cycle by the model.
        en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            adc = 14'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                freq = 16'($urandom_range(0, 7));
                wt   = 16'($urandom_range(0, 8));
                pol  = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 149) == 0) en = ~en;
            step();
        end
        en = 1'b0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
